// File: rtl/coherent_avg_frame_pkg.sv
// Shared types and defaults for the coherent-average frame engine.
// The accumulator is sized so N full-scale samples can be summed without overflow.
package coherent_avg_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAccum = 2'd1,
      StDrain = 2'd2
   } state_e;

   localparam int unsigned DefQ     = 32;
   localparam int unsigned DefM     = 128;
   localparam int unsigned DefLog2N = 4;

   function automatic int unsigned acc_width(input int unsigned q, input int unsigned log2_n);
      return q + log2_n;
   endfunction

endpackage

// File: rtl/coherent_avg_frame_if.sv
// Sample-in / averaged-frame-out signal bundle for coherent_avg_frame.
// The master side is the environment (producer and consumer); the slave side is the engine.
interface coherent_avg_frame_if #(
   parameter int unsigned Q = coherent_avg_pkg::DefQ
);

   logic         start;
   logic         x_valid;
   logic [Q-1:0] x;
   logic         busy;
   logic         y_valid;
   logic         y_ready;
   logic [Q-1:0] y;
   logic         y_last;
   logic         done;

   modport master (
      output start, x_valid, x, y_ready,
      input  busy, y_valid, y, y_last, done
   );

   modport slave (
      input  start, x_valid, x, y_ready,
      output busy, y_valid, y, y_last, done
   );

endinterface

// File: rtl/coherent_avg_frame_acc_mem.sv
// M x W accumulator memory: one synchronous write port and two asynchronous read ports
// (accumulate-side and drain-side), shaped for distributed RAM inference.
module avg_acc_mem #(
   parameter int unsigned M  = 128,
   parameter int unsigned W  = 36,
   localparam int unsigned AW = $clog2(M)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [W-1:0]  rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [W-1:0]  rdata_b_o
);

   logic [W-1:0] mem_q [M];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/coherent_avg_frame.sv
// Coherent-average engine: sums N = 2^LOG2_N frames of M samples by read-modify-write,
// then streams the averaged frame out over valid/ready, one word per index.
module coherent_avg_frame
   import coherent_avg_pkg::*;
#(
   parameter int unsigned Q      = DefQ,
   parameter int unsigned M      = DefM,
   parameter int unsigned LOG2_N = DefLog2N
) (
   input logic                 clk,
   input logic                 reset,
   coherent_avg_frame_if.slave bus
);

   localparam int unsigned   ACC_W   = acc_width(Q, LOG2_N);
   localparam int unsigned   AW      = $clog2(M);
   localparam logic [AW-1:0] LastIdx = AW'(M - 1);

   state_e              state_q, state_d;
   logic [AW-1:0]       i_q, i_d;
   logic [AW-1:0]       j_q, j_d;
   logic [LOG2_N-1:0]   k_q, k_d;
   logic [Q-1:0]        y_q, y_d;
   logic                y_valid_q, y_valid_d;
   logic                y_last_q, y_last_d;
   logic                done_q, done_d;

   logic                mem_we;
   logic [ACC_W-1:0]    mem_wdata;
   logic [ACC_W-1:0]    acc_rdata;
   logic [ACC_W-1:0]    drain_rdata;
   logic [AW-1:0]       drain_addr;
   logic [ACC_W-1:0]    x_ext;
   logic [Q-1:0]        avg_word;
   logic                accept_y;
   logic                unused_frac;

   assign x_ext    = {{LOG2_N{bus.x[Q-1]}}, bus.x};
   assign accept_y = y_valid_q & bus.y_ready;

   // Look ahead one index on a mid-frame handshake so y reloads in the same edge.
   assign drain_addr = (accept_y && (j_q != LastIdx)) ? j_q + AW'(1) : j_q;

   // Taking the upper Q bits of the sign-carrying sum is the floor (>>> LOG2_N) average.
   assign avg_word    = drain_rdata[LOG2_N +: Q];
   assign unused_frac = ^drain_rdata[LOG2_N-1:0];

   avg_acc_mem #(
      .M (M),
      .W (ACC_W)
   ) u_mem (
      .clk_i     (clk),
      .we_i      (mem_we),
      .waddr_i   (i_q),
      .wdata_i   (mem_wdata),
      .raddr_a_i (i_q),
      .rdata_a_o (acc_rdata),
      .raddr_b_i (drain_addr),
      .rdata_b_o (drain_rdata)
   );

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      y_d       = y_q;
      y_valid_d = y_valid_q;
      y_last_d  = y_last_q;
      done_d    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = acc_rdata + x_ext;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StAccum;
               i_d     = '0;
               k_d     = '0;
            end
         end
         StAccum: begin
            if (bus.x_valid) begin
               mem_we = 1'b1;
               // Frame 0 overwrites, so whatever the memory held before never leaks in.
               if (k_q == '0) begin
                  mem_wdata = x_ext;
               end
               if (i_q == LastIdx) begin
                  i_d = '0;
                  k_d = k_q + LOG2_N'(1);
                  if (k_q == '1) begin
                     state_d = StDrain;
                     j_d     = '0;
                  end
               end else begin
                  i_d = i_q + AW'(1);
               end
            end
         end
         StDrain: begin
            if (!y_valid_q) begin
               y_valid_d = 1'b1;
               y_d       = avg_word;
               y_last_d  = (j_q == LastIdx);
            end else if (bus.y_ready) begin
               if (j_q == LastIdx) begin
                  y_valid_d = 1'b0;
                  y_last_d  = 1'b0;
                  done_d    = 1'b1;
                  state_d   = StIdle;
               end else begin
                  j_d      = drain_addr;
                  y_d      = avg_word;
                  y_last_d = (drain_addr == LastIdx);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         y_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         y_last_q  <= y_last_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.y_valid = y_valid_q;
   assign bus.y       = y_q;
   assign bus.y_last  = y_last_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_coherent_avg_frame.sv
// Directed bench for coherent_avg_frame at M=4, LOG2_N=4, Q=16 with hand-computed averages.
module tb_coherent_avg_frame;

   localparam int unsigned Q      = 16;
   localparam int unsigned M      = 4;
   localparam int unsigned LOG2_N = 4;
   localparam int unsigned NS     = M * (1 << LOG2_N);

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   coherent_avg_frame_if #(.Q(Q)) bus ();

   coherent_avg_frame #(
      .Q      (Q),
      .M      (M),
      .LOG2_N (LOG2_N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [Q-1:0] smp [NS];
   logic [Q-1:0] ys  [M];
   logic [M-1:0] lasts;
   int           lat;
   logic         done_ok;

   task automatic fill_const(input logic [Q-1:0] v);
      for (int n = 0; n < NS; n++) smp[n] = v;
   endtask

   // One acquisition: start pulse, then NS samples, optionally with gaps and a stray start.
   task automatic drive_acq(input bit gap, input bit poke_start);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 0; n < NS; n++) begin
         bus.x_valid = 1'b1;
         bus.x       = smp[n];
         @(negedge clk);
         if (gap) begin
            bus.x_valid = 1'b0;
            if (poke_start && n == 20) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
         end
      end
      bus.x_valid = 1'b0;
   endtask

   // Drain with y_ready held high; captures words, y_last flags and the done pulse shape.
   task automatic collect();
      lat          = 0;
      done_ok      = 1'b0;
      bus.y_ready  = 1'b1;
      while (!bus.y_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      for (int w = 0; w < M; w++) begin
         ys[w]    = bus.y_valid ? bus.y : 'x;
         lasts[w] = bus.y_last & bus.y_valid;
         @(negedge clk);
      end
      done_ok = bus.done && !bus.y_valid && !bus.busy;
      @(negedge clk);
      done_ok = done_ok && !bus.done;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.y !== '0 || bus.y_last !== 1'b0 ||
          bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b y_valid=%b y=%h y_last=%b done=%b, required all 0",
                  bus.busy, bus.y_valid, bus.y, bus.y_last, bus.done);
      end
   endtask

   task automatic test_const_100();
      fill_const(Q'(100));
      drive_acq(1'b0, 1'b0);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL const100_busy: got %b, required 1", bus.busy);
      end
      collect();
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL const100_latency: got %0d, required 1", lat);
      end
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== Q'(100)) begin
            errors++;
            $display("FAIL const100_y%0d: got %0d, required 100", w, $signed(ys[w]));
         end
      end
      checks++;
      if (lasts !== 4'b1000) begin
         errors++;
         $display("FAIL const100_y_last: got %b, required 1000", lasts);
      end
      checks++;
      if (done_ok !== 1'b1) begin
         errors++;
         $display("FAIL const100_done: got %b, required one-cycle pulse after last word", done_ok);
      end
   endtask

   task automatic test_signed_floor();
      logic [Q-1:0] e;
      fill_const(Q'(-7));
      drive_acq(1'b0, 1'b0);
      collect();
      e = Q'(-7);
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== e) begin
            errors++;
            $display("FAIL neg7_y%0d: got %0d, required -7", w, $signed(ys[w]));
         end
      end
      // Alternating frames of 1 and 2: sum 24, floor(24/16) = 1.
      for (int n = 0; n < NS; n++) smp[n] = (((n / M) % 2) == 0) ? Q'(1) : Q'(2);
      drive_acq(1'b0, 1'b0);
      collect();
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== Q'(1)) begin
            errors++;
            $display("FAIL alt12_y%0d: got %0d, required 1", w, $signed(ys[w]));
         end
      end
      // One frame of -1: sum -1 floors to -1.
      for (int n = 0; n < NS; n++) smp[n] = (n < M) ? Q'(-1) : Q'(0);
      drive_acq(1'b0, 1'b0);
      collect();
      e = Q'(-1);
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== e) begin
            errors++;
            $display("FAIL neg1_y%0d: got %0d, required -1", w, $signed(ys[w]));
         end
      end
   endtask

   task automatic test_backpressure();
      int wait_cnt;
      for (int n = 0; n < NS; n++) smp[n] = Q'(50 * ((n % M) + 1));
      drive_acq(1'b0, 1'b0);
      bus.y_ready = 1'b1;
      wait_cnt    = 0;
      while (!bus.y_valid && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y !== Q'(50)) begin
         errors++;
         $display("FAIL bp_word0: y_valid=%b y=%0d, required 1/50", bus.y_valid, bus.y);
      end
      @(negedge clk);
      checks++;
      if (bus.y !== Q'(100)) begin
         errors++;
         $display("FAIL bp_word1: got %0d, required 100", bus.y);
      end
      @(negedge clk);
      bus.y_ready = 1'b0;
      bus.start   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         checks++;
         if (bus.y !== Q'(150) || bus.y_valid !== 1'b1 || bus.y_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: y=%0d y_valid=%b y_last=%b, required 150/1/0",
                     c, bus.y, bus.y_valid, bus.y_last);
         end
      end
      bus.y_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.y !== Q'(200) || bus.y_last !== 1'b1) begin
         errors++;
         $display("FAIL bp_word3: y=%0d y_last=%b, required 200/1", bus.y, bus.y_last);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.y !== Q'(200)) begin
         errors++;
         $display("FAIL bp_done: done=%b busy=%b y=%0d, required 1/0/200",
                  bus.done, bus.busy, bus.y);
      end
   endtask

   task automatic test_gaps_and_start();
      // Samples offered while idle must be ignored.
      bus.x_valid = 1'b1;
      bus.x       = Q'(999);
      repeat (3) @(negedge clk);
      bus.x_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_x_valid_busy: got %b, required 0", bus.busy);
      end
      fill_const(Q'(100));
      drive_acq(1'b1, 1'b1);
      collect();
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== Q'(100)) begin
            errors++;
            $display("FAIL gaps_y%0d: got %0d, required 100", w, $signed(ys[w]));
         end
      end
      checks++;
      if (lasts !== 4'b1000 || done_ok !== 1'b1) begin
         errors++;
         $display("FAIL gaps_last_done: y_last=%b done_ok=%b, required 1000/1", lasts, done_ok);
      end
   endtask

   task automatic test_reset_mid_accum();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         bus.x_valid = 1'b1;
         bus.x       = Q'(9);
         @(negedge clk);
      end
      bus.x_valid = 1'b0;
      reset       = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: busy=%b y_valid=%b, required 0/0", bus.busy, bus.y_valid);
      end
      fill_const(Q'(5));
      drive_acq(1'b0, 1'b0);
      collect();
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== Q'(5)) begin
            errors++;
            $display("FAIL midreset_y%0d: got %0d, required 5", w, $signed(ys[w]));
         end
      end
   endtask

   task automatic test_full_scale();
      logic [Q-1:0] e;
      e = 16'h7fff;
      fill_const(e);
      drive_acq(1'b0, 1'b0);
      collect();
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== e) begin
            errors++;
            $display("FAIL fs_pos_y%0d: got %0d, required 32767", w, $signed(ys[w]));
         end
      end
      e = 16'h8000;
      fill_const(e);
      drive_acq(1'b0, 1'b0);
      collect();
      for (int w = 0; w < M; w++) begin
         checks++;
         if (ys[w] !== e) begin
            errors++;
            $display("FAIL fs_neg_y%0d: got %0d, required -32768", w, $signed(ys[w]));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start   = 1'b0;
      bus.x_valid = 1'b0;
      bus.x       = '0;
      bus.y_ready = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      reset = 1'b0;
      test_const_100();
      test_signed_floor();
      test_backpressure();
      test_gaps_and_start();
      test_reset_mid_accum();
      test_full_scale();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
